// File: rtl/grey_pkg.sv
// Shared Gray-code helpers and mode encodings for the divided Gray counter.
// Functions work on any width up to GREY_MAXW; unused upper bits must be zero.
package grey_pkg;

    localparam int GREY_MAXW = 32;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef logic [GREY_MAXW-1:0] gvec_t;

    function automatic gvec_t bin2grey(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gvec_t grey2bin(input gvec_t g);
        gvec_t b;
        b = g;
        for (int i = GREY_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next Gray value of a w-bit counter, wrapping modulo 2**w.
    function automatic gvec_t grey_next(input gvec_t g, input logic up, input int unsigned w);
        gvec_t b;
        gvec_t mask;
        mask = (w >= GREY_MAXW) ? '1 : ((gvec_t'(1) << w) - gvec_t'(1));
        b    = grey2bin(g);
        b    = up ? b + gvec_t'(1) : b - gvec_t'(1);
        return bin2grey(b & mask);
    endfunction

endpackage

// File: rtl/grey_div_prescaler.sv
// Runtime-ratio prescaler: step_o fires combinationally when pre_q reaches div_i.
// Zero latency from compare to step; no backpressure, en_i freezes the count.
module grey_div_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             w_rst,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_o
);

    logic [DIV_W-1:0] pre_q;
    logic [DIV_W-1:0] pre_d;
    logic             hit;

    // >= rather than == so a lowered divisor fires immediately instead of overrunning.
    assign hit    = (pre_q >= div_i);
    assign step_o = en_i & hit & ~clear_i & ~load_i;

    always_comb begin
        pre_d = pre_q;
        if (clear_i || load_i) begin
            pre_d = '0;
        end else if (en_i) begin
            pre_d = hit ? '0 : pre_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/grey_div_counter.sv
// Prescaled up/down Gray counter with free-run/one-shot modes, load and clear.
// Outputs registered; a step updates them on the edge of the prescaler compare; no backpressure.
module grey_div_counter
    import grey_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int GREY_W = 6
) (
    input  logic              clk,
    input  logic              w_rst,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              dir_i,
    input  logic              mode_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [GREY_W-1:0] load_val_i,
    output logic              tick_o,
    output logic              wrap_o,
    output logic              done_o,
    output logic [GREY_W-1:0] grey_o,
    output logic [GREY_W-1:0] bin_o
);

    localparam logic [GREY_W-1:0] CNT_MAX = '1;

    logic              step;
    logic              at_end;
    logic              next_end;
    logic [GREY_W-1:0] bin_q,  bin_d;
    logic [GREY_W-1:0] grey_q, grey_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;

    grey_div_prescaler #(
        .DIV_W (DIV_W)
    ) u_pre (
        .clk     (clk),
        .w_rst   (w_rst),
        .en_i    (en_i),
        .clear_i (clear_i),
        .load_i  (load_i),
        .div_i   (div_i),
        .step_o  (step)
    );

    always_comb begin
        bin_d    = bin_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        done_d   = done_q;
        at_end   = dir_i ? (bin_q == CNT_MAX) : (bin_q == '0);
        next_end = 1'b0;
        if (clear_i) begin
            bin_d  = '0;
            done_d = 1'b0;
        end else if (load_i) begin
            bin_d  = load_val_i;
            done_d = 1'b0;
        end else if (step && !(mode_i == MODE_ONESHOT && at_end)) begin
            // at_end here can only be true in free-run, so it is exactly the wrap condition.
            bin_d    = dir_i ? bin_q + GREY_W'(1) : bin_q - GREY_W'(1);
            tick_d   = 1'b1;
            wrap_d   = at_end;
            next_end = dir_i ? (bin_d == CNT_MAX) : (bin_d == '0);
            if (mode_i == MODE_ONESHOT && next_end) begin
                done_d = 1'b1;
            end
        end
        grey_d = GREY_W'(bin2grey(gvec_t'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            bin_q  <= '0;
            grey_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            grey_q <= grey_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign tick_o = tick_q;
    assign wrap_o = wrap_q;
    assign done_o = done_q;
    assign grey_o = grey_q;
    assign bin_o  = bin_q;

endmodule

// File: tb/tb_grey_div_counter.sv
// Scoreboarded bench for grey_div_counter: expected ticks queued by the driver, matched by a monitor.
module tb_grey_div_counter;

    localparam int DIV_W  = 8;
    localparam int GREY_W = 6;

    logic              clk = 1'b0;
    logic              w_rst;
    logic              en_i;
    logic [DIV_W-1:0]  div_i;
    logic              dir_i;
    logic              mode_i;
    logic              clear_i;
    logic              load_i;
    logic [GREY_W-1:0] load_val_i;
    logic              tick_o;
    logic              wrap_o;
    logic              done_o;
    logic [GREY_W-1:0] grey_o;
    logic [GREY_W-1:0] bin_o;

    grey_div_counter #(
        .DIV_W  (DIV_W),
        .GREY_W (GREY_W)
    ) dut (
        .clk        (clk),
        .w_rst      (w_rst),
        .en_i       (en_i),
        .div_i      (div_i),
        .dir_i      (dir_i),
        .mode_i     (mode_i),
        .clear_i    (clear_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .tick_o     (tick_o),
        .wrap_o     (wrap_o),
        .done_o     (done_o),
        .grey_o     (grey_o),
        .bin_o      (bin_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [GREY_W-1:0] grey;
        logic [GREY_W-1:0] bin;
        logic              wrap;
        logic              done;
    } exp_t;

    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int unsigned c, input logic [GREY_W-1:0] g,
                        input logic [GREY_W-1:0] b, input logic w, input logic d);
        exp_t e;
        e.cyc  = c;
        e.grey = g;
        e.bin  = b;
        e.wrap = w;
        e.done = d;
        expq.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: each observed tick is matched against the next queued expectation.
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (tick_o === 1'b1) begin
            a.cyc  = cyc;
            a.grey = grey_o;
            a.bin  = bin_o;
            a.wrap = wrap_o;
            a.done = done_o;
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_tick: got cyc=%0d grey=%b bin=%0d, expected no tick", cyc, grey_o, bin_o);
            end else begin
                e = expq.pop_front();
                chk("tick{cyc,grey,bin,wrap,done}", 64'(a), 64'(e));
            end
        end else if (wrap_o !== 1'b0) begin
            chk("wrap_without_tick", 64'(wrap_o), 64'd0);
        end
    end

    initial begin
        int unsigned base;
        logic [GREY_W-1:0] kb;

        w_rst      = 1'b1;
        en_i       = 1'b0;
        div_i      = '0;
        dir_i      = 1'b1;
        mode_i     = 1'b0;
        clear_i    = 1'b0;
        load_i     = 1'b0;
        load_val_i = '0;

        // Reset, then idle with en_i=0.
        cycles(2);
        chk("reset_outputs", 64'({tick_o, wrap_o, done_o, grey_o, bin_o}), 64'd0);
        w_rst = 1'b0;
        cycles(100);
        chk("idle_hold", 64'({tick_o, done_o, grey_o, bin_o}), 64'd0);

        // Divide by 13, free-run up.
        div_i = 8'd12;
        dir_i = 1'b1;
        mode_i = 1'b0;
        en_i  = 1'b1;
        base  = cyc;
        push(base + 13, 6'b000001, 6'd1, 1'b0, 1'b0);
        push(base + 26, 6'b000011, 6'd2, 1'b0, 1'b0);
        push(base + 39, 6'b000010, 6'd3, 1'b0, 1'b0);
        push(base + 52, 6'b000110, 6'd4, 1'b0, 1'b0);
        push(base + 65, 6'b000111, 6'd5, 1'b0, 1'b0);
        cycles(65);
        en_i = 1'b0;
        chk("div13_bin", 64'(bin_o), 64'd5);

        // Clear, then div=0 free-run up across the wrap.
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        chk("clear_outputs", 64'({done_o, grey_o, bin_o}), 64'd0);
        div_i = 8'd0;
        en_i  = 1'b1;
        base  = cyc;
        for (int k = 1; k <= 64; k++) begin
            kb = 6'(k);
            push(base + k, kb ^ (kb >> 1), kb, (k == 64), 1'b0);
        end
        cycles(64);
        en_i = 1'b0;
        chk("wrap_up_bin", 64'(bin_o), 64'd0);
        dir_i = 1'b0;
        en_i  = 1'b1;
        base  = cyc;
        push(base + 1, 6'b100000, 6'd63, 1'b1, 1'b0);
        cycles(1);
        en_i  = 1'b0;
        dir_i = 1'b1;

        // One-shot up from 61.
        mode_i     = 1'b1;
        load_val_i = 6'd61;
        load_i     = 1'b1;
        cycles(1);
        load_i = 1'b0;
        chk("load_grey", 64'(grey_o), 64'(6'b100011));
        chk("load_bin", 64'(bin_o), 64'd61);
        div_i = 8'd3;
        en_i  = 1'b1;
        base  = cyc;
        push(base + 4, 6'b100001, 6'd62, 1'b0, 1'b0);
        push(base + 8, 6'b100000, 6'd63, 1'b0, 1'b1);
        cycles(48);
        chk("oneshot_done", 64'(done_o), 64'd1);
        chk("oneshot_hold_bin", 64'(bin_o), 64'd63);
        en_i    = 1'b0;
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        chk("oneshot_clear", 64'({done_o, grey_o, bin_o}), 64'd0);
        mode_i = 1'b0;

        // Lower the divisor below the running prescaler.
        div_i = 8'd200;
        en_i  = 1'b1;
        base  = cyc;
        cycles(150);
        div_i = 8'd20;
        push(base + 151, 6'b000001, 6'd1, 1'b0, 1'b0);
        push(base + 172, 6'b000011, 6'd2, 1'b0, 1'b0);
        push(base + 193, 6'b000010, 6'd3, 1'b0, 1'b0);
        cycles(43);
        en_i = 1'b0;

        // Clear beats load and step on the same edge.
        div_i      = 8'd0;
        en_i       = 1'b1;
        load_val_i = 6'd10;
        clear_i    = 1'b1;
        load_i     = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        load_i  = 1'b0;
        en_i    = 1'b0;
        chk("clear_wins", 64'({tick_o, grey_o, bin_o}), 64'd0);

        // Reset in the middle of counting.
        en_i = 1'b1;
        base = cyc;
        push(base + 1, 6'b000001, 6'd1, 1'b0, 1'b0);
        push(base + 2, 6'b000011, 6'd2, 1'b0, 1'b0);
        push(base + 3, 6'b000010, 6'd3, 1'b0, 1'b0);
        cycles(3);
        w_rst = 1'b1;
        cycles(1);
        chk("midcount_reset", 64'({tick_o, wrap_o, done_o, grey_o, bin_o}), 64'd0);
        w_rst = 1'b0;
        en_i  = 1'b0;
        cycles(2);

        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
